// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode encodings, FSM states and
// opcode groups. The BCD state only exists when ALU_BCD_EN is defined.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b1110,
    OP_SUB = 4'b1101,
    OP_MUL = 4'b1100,
    OP_DIV = 4'b1011,
    OP_MOD = 4'b1010,
    OP_AND = 4'b1001,
    OP_OR  = 4'b1000,
    OP_XOR = 4'b0111,
    OP_SHL = 4'b0110,
    OP_SHR = 4'b0101
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_ITER = 3'd2,
`ifdef ALU_BCD_EN
    ST_BCD  = 3'd3,
`endif
    ST_DONE = 3'd4
  } state_t;

  // Opcodes that need the WIDTH-cycle iterative unit; everything else is single-cycle.
  localparam int N_ITER_OPS = 3;
  localparam logic [4*N_ITER_OPS-1:0] ITER_OPS = {OP_MUL, OP_DIV, OP_MOD};

  function automatic logic is_iter_op(input logic [3:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_ITER_OPS; i++) begin
      if (op == ITER_OPS[i*4 +: 4]) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Shift-add multiplier and restoring divider sharing one 2*WIDTH accumulator.
// Outputs reflect the accumulator after the step currently being applied, so
// the caller can capture the final result on the same edge as the last step.
module alu_iter_unit #(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_mul,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [WIDTH-1:0]   o_quo,
  output logic [WIDTH-1:0]   o_rem,
  output logic [2*WIDTH-1:0] o_prod
);

  // Multiply: {partial product, multiplier}; divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_mul;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_trial;

  // One iteration of either algorithm, selected by the latched mode.
  always_comb begin
    w_add      = '0;
    w_shift    = '0;
    w_trial    = '0;
    w_acc_next = r_acc;
    if (r_mul) begin
      if (r_acc[0]) begin
        w_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
      end else begin
        w_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
      end
      w_acc_next = {w_add, r_acc[WIDTH-1:1]};
    end else begin
      // Remainder shifted left can need WIDTH+1 bits before the trial subtract.
      w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
      w_trial = w_shift[WIDTH-1:0] - r_opnd;
      if (w_shift >= {1'b0, r_opnd}) begin
        w_acc_next = {w_trial, r_acc[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_next = {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Load operands on accept, then advance one step per enabled cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_opnd <= '0;
      r_mul  <= 1'b0;
    end else if (i_load) begin
      r_mul  <= i_mul;
      r_opnd <= i_mul ? i_a : i_b;
      r_acc  <= i_mul ? {{WIDTH{1'b0}}, i_b} : {{WIDTH{1'b0}}, i_a};
    end else if (i_step) begin
      r_acc <= w_acc_next;
    end
  end

  assign o_prod = w_acc_next;
  assign o_quo  = w_acc_next[WIDTH-1:0];
  assign o_rem  = w_acc_next[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU top: single-cycle logic/arith ops, iterative mul/div/mod,
// registered result and flags, done pulse. Optional double-dabble BCD stage
// compiled in with the ALU_BCD_EN macro; without it o_bcd is tied to zero.
module alu_multiciclo
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [3:0]            i_op,
  input  logic [WIDTH-1:0]      i_a,
  input  logic [WIDTH-1:0]      i_b,
  input  logic                  i_cin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [WIDTH-1:0]      o_s,
  output logic                  o_cout,
  output logic                  o_z,
  output logic                  o_n,
  output logic                  o_v,
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

  state_t             r_state;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_cin;
  logic [CW-1:0]      r_cnt;
  logic               w_leave;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_s;
  logic               w_cout;
  logic               w_n;
  logic               w_v;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_prod;

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load ((r_state == ST_IDLE) && i_start),
    .i_step (r_state == ST_ITER),
    .i_mul  (i_op == OP_MUL),
    .i_a    (i_a),
    .i_b    (i_b),
    .o_quo  (w_quo),
    .o_rem  (w_rem),
    .o_prod (w_prod)
  );

  // Last cycle of CALC or ITER: the edge that commits result and flags.
  always_comb begin
    if (r_state == ST_CALC) begin
      w_leave = 1'b1;
    end else if ((r_state == ST_ITER) && (r_cnt == LAST)) begin
      w_leave = 1'b1;
    end else begin
      w_leave = 1'b0;
    end
  end

  // Result and flag values for the latched opcode (Z is derived when registering).
  always_comb begin
    w_sum  = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
    w_diff = {1'b0, r_a} - {1'b0, r_b} - {{WIDTH{1'b0}}, r_cin};
    w_s    = '0;
    w_cout = 1'b0;
    w_n    = 1'b0;
    w_v    = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_s    = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
        w_n    = w_sum[WIDTH-1];
        w_v    = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_s    = w_diff[WIDTH-1:0];
        w_cout = w_diff[WIDTH];
        w_n    = w_diff[WIDTH-1];
        w_v    = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_MUL: begin
        w_s = w_prod[WIDTH-1:0];
        w_v = |w_prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        if (r_b == '0) begin
          w_s = '1;
          w_v = 1'b1;
        end else begin
          w_s = w_quo;
        end
      end
      OP_MOD: begin
        if (r_b == '0) begin
          w_s = '0;
          w_v = 1'b1;
        end else begin
          w_s = w_rem;
        end
      end
      OP_AND: w_s = r_a & r_b;
      OP_OR:  w_s = r_a | r_b;
      OP_XOR: w_s = r_a ^ r_b;
      OP_SHL: begin
        w_s    = {r_a[WIDTH-2:0], 1'b0};
        w_cout = r_a[WIDTH-1];
      end
      OP_SHR: begin
        w_s    = {1'b0, r_a[WIDTH-1:1]};
        w_cout = r_a[0];
      end
      default: w_s = '0;
    endcase
  end

  // Sequencer: accepts requests in IDLE only, times CALC/ITER/BCD, drives busy/done.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_op    <= 4'b0000;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_cnt   <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_op    <= i_op;
            r_a     <= i_a;
            r_b     <= i_b;
            r_cin   <= i_cin;
            r_cnt   <= '0;
            o_busy  <= 1'b1;
            r_state <= is_iter_op(i_op) ? ST_ITER : ST_CALC;
          end
        end
        ST_CALC, ST_ITER: begin
          if (w_leave) begin
            r_cnt <= '0;
`ifdef ALU_BCD_EN
            r_state <= ST_BCD;
`else
            r_state <= ST_DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
`ifdef ALU_BCD_EN
        ST_BCD: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= ST_DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
`endif
        ST_DONE: r_state <= ST_IDLE;
        default: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Result and flag registers: written only when CALC/ITER completes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_s    <= '0;
      o_cout <= 1'b0;
      o_z    <= 1'b0;
      o_n    <= 1'b0;
      o_v    <= 1'b0;
    end else if (w_leave) begin
      o_s    <= w_s;
      o_cout <= w_cout;
      o_z    <= (w_s == '0);
      o_n    <= w_n;
      o_v    <= w_v;
    end
  end

`ifdef ALU_BCD_EN
  localparam int BW = 4 * DIGITS;

  logic [WIDTH-1:0] r_bin;
  logic [BW-1:0]    r_bcd_work;
  logic [BW-1:0]    w_bcd_adj;
  logic [BW-1:0]    w_bcd_next;

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
  always_comb begin
    w_bcd_adj = r_bcd_work;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd_work[4*d +: 4] >= 4'd5) begin
        w_bcd_adj[4*d +: 4] = r_bcd_work[4*d +: 4] + 4'd3;
      end else begin
        w_bcd_adj[4*d +: 4] = r_bcd_work[4*d +: 4];
      end
    end
    // The top bit shifted out is always zero because 10^DIGITS exceeds the range of S.
    w_bcd_next = BW'({w_bcd_adj, r_bin[WIDTH-1]});
  end

  // BCD converter: seeded from the new result, publishes digits on its final step.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bin      <= '0;
      r_bcd_work <= '0;
      o_bcd      <= '0;
    end else if (w_leave) begin
      r_bin      <= w_s;
      r_bcd_work <= '0;
    end else if (r_state == ST_BCD) begin
      r_bin      <= {r_bin[WIDTH-2:0], 1'b0};
      r_bcd_work <= w_bcd_next;
      if (r_cnt == LAST) begin
        o_bcd <= w_bcd_next;
      end
    end
  end
`else
  assign o_bcd = '0;
`endif

endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo (WIDTH=8, DIGITS=3). Expected values
// come from an arithmetic reference model; the BCD expectations and latency
// follow whether ALU_BCD_EN is defined for the build.
module tb_alu_multiciclo;

  localparam int W  = 8;
  localparam int D  = 3;
  localparam int M  = 256;
  localparam int HB = 128;
`ifdef ALU_BCD_EN
  localparam bit BCD_ON = 1'b1;
`else
  localparam bit BCD_ON = 1'b0;
`endif

  logic           clk;
  logic           i_rst;
  logic           i_start;
  logic [3:0]     i_op;
  logic [W-1:0]   i_a;
  logic [W-1:0]   i_b;
  logic           i_cin;
  logic           o_busy;
  logic           o_done;
  logic [W-1:0]   o_s;
  logic           o_cout;
  logic           o_z;
  logic           o_n;
  logic           o_v;
  logic [4*D-1:0] o_bcd;

  int checks;
  int failures;

  alu_multiciclo #(.WIDTH(W), .DIGITS(D)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_op    (i_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_cin   (i_cin),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_s     (o_s),
    .o_cout  (o_cout),
    .o_z     (o_z),
    .o_n     (o_n),
    .o_v     (o_v),
    .o_bcd   (o_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU using plain integer arithmetic on unsigned/signed values.
  function automatic void ref_alu(input int op, input int a, input int b, input int cin,
                                  output int s, output int cout, output int z,
                                  output int n, output int v);
    int t;
    int sa;
    int sb;
    int ts;
    sa = (a >= HB) ? a - M : a;
    sb = (b >= HB) ? b - M : b;
    s = 0; cout = 0; n = 0; v = 0;
    case (op)
      14: begin
        t = a + b + cin; s = t % M; cout = (t >= M) ? 1 : 0;
        ts = sa + sb + cin; v = (ts > HB - 1 || ts < -HB) ? 1 : 0;
        n = (s >= HB) ? 1 : 0;
      end
      13: begin
        t = a - b - cin; s = (t + M) % M; cout = (t < 0) ? 1 : 0;
        ts = sa - sb - cin; v = (ts > HB - 1 || ts < -HB) ? 1 : 0;
        n = (s >= HB) ? 1 : 0;
      end
      12: begin t = a * b; s = t % M; v = (t >= M) ? 1 : 0; end
      11: begin if (b == 0) begin s = M - 1; v = 1; end else s = a / b; end
      10: begin if (b == 0) begin s = 0; v = 1; end else s = a % b; end
      9:  s = a & b;
      8:  s = a | b;
      7:  s = a ^ b;
      6:  begin s = (a * 2) % M; cout = (a >= HB) ? 1 : 0; end
      5:  begin s = a / 2; cout = a % 2; end
      default: s = 0;
    endcase
    z = (s == 0) ? 1 : 0;
  endfunction

  function automatic int ref_bcd(input int s);
    if (!BCD_ON) return 0;
    return (s / 100) * 256 + ((s / 10) % 10) * 16 + (s % 10);
  endfunction

  function automatic int ref_lat(input int op);
    int l;
    l = (op == 12 || op == 11 || op == 10) ? W : 1;
    if (BCD_ON) l = l + W;
    return l;
  endfunction

  // One transaction; optional start pokes while busy and during the done cycle.
  task automatic run_op(input int op, input int a, input int b, input int cin, input bit poke);
    int s, cout, z, n, v, lat, cyc, bsy;
    string t;
    ref_alu(op, a, b, cin, s, cout, z, n, v);
    lat = ref_lat(op);
    t = $sformatf("op=%0d a=%0d b=%0d c=%0d", op, a, b, cin);
    @(negedge clk);
    i_start = 1'b1; i_op = op[3:0]; i_a = a[7:0]; i_b = b[7:0]; i_cin = cin[0];
    @(posedge clk); #1;
    i_start = 1'b0;
    i_op = 4'($urandom); i_a = 8'($urandom); i_b = 8'($urandom); i_cin = 1'($urandom);
    cyc = 0; bsy = 0;
    if (o_busy) bsy++;
    while (!o_done && cyc < 100) begin
      if (poke && cyc == 2) begin
        i_start = 1'b1; i_op = 4'b1110; i_a = 8'h55; i_b = 8'h0F;
      end else begin
        i_start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (o_busy) bsy++;
    end
    i_start = 1'b0;
    check({"latency ", t}, cyc, lat);
    check({"busy_cycles ", t}, bsy, lat);
    check({"S ", t}, o_s, s);
    check({"Cout ", t}, o_cout, cout);
    check({"Z ", t}, o_z, z);
    check({"N ", t}, o_n, n);
    check({"V ", t}, o_v, v);
    check({"bcd ", t}, o_bcd, ref_bcd(s));
    // Start raised during the done cycle must be ignored.
    i_start = 1'b1; i_op = 4'b1001;
    @(posedge clk); #1;
    i_start = 1'b0;
    check({"done_pulse ", t}, o_done, 0);
    check({"start_in_done_ignored ", t}, o_busy, 0);
    check({"S_hold ", t}, o_s, s);
  endtask

  initial begin
    int seen;
    int ops [16];
    checks = 0; failures = 0;
    i_rst = 1'b1; i_start = 1'b0; i_op = 4'b0000; i_a = '0; i_b = '0; i_cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_S", o_s, 0);
    check("reset_flags", {o_cout, o_z, o_n, o_v}, 0);
    check("reset_busy_done", {o_busy, o_done}, 0);
    check("reset_bcd", o_bcd, 0);
    @(negedge clk);
    i_rst = 1'b0;

    run_op(14, 127, 1, 0, 1'b0);
    run_op(13, 5, 7, 0, 1'b0);
    run_op(12, 16, 16, 0, 1'b0);
    run_op(12, 15, 17, 0, 1'b1);
    run_op(11, 200, 7, 0, 1'b0);
    run_op(10, 200, 7, 0, 1'b1);
    run_op(11, 9, 0, 0, 1'b0);
    run_op(10, 9, 0, 1, 1'b0);
    run_op(0, 33, 44, 1, 1'b0);
    run_op(6, 8'hA5, 0, 0, 1'b1);
    run_op(5, 8'hA5, 0, 0, 1'b0);
    run_op(9, 8'hF0, 8'h3C, 0, 1'b0);
    run_op(8, 8'hF0, 8'h3C, 0, 1'b0);
    run_op(7, 8'hF0, 8'h3C, 0, 1'b0);
    run_op(14, 255, 255, 1, 1'b0);
    run_op(13, 128, 1, 1, 1'b0);
    run_op(12, 15, 17, 0, 1'b0);

    // Reset in the middle of an iterative op aborts it with no done pulse.
    @(negedge clk);
    i_start = 1'b1; i_op = 4'b1100; i_a = 8'd13; i_b = 8'd11;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_busy", o_busy, 1);
    i_rst = 1'b1;
    #1;
    check("midreset_S", o_s, 0);
    check("midreset_flags", {o_cout, o_z, o_n, o_v}, 0);
    check("midreset_busy_done", {o_busy, o_done}, 0);
    check("midreset_bcd", o_bcd, 0);
    @(negedge clk);
    i_rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (o_done || o_busy) seen = 1;
    end
    check("midreset_no_done", seen, 0);

    ops = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    for (int i = 0; i < 40; i++) begin
      run_op(ops[$urandom_range(15, 0)], $urandom_range(255, 0),
             (i % 8 == 0) ? 0 : $urandom_range(255, 0), $urandom_range(1, 0), i[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
